// File: rtl/wb_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stream_reader_pkg
// Description : Shared definitions for the Wishbone block-read streamer.
//               Holds the controller state encoding and the bus byte-select
//               constant.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_stream_reader_pkg;

    // Controller states: wait for a start, issue word reads, signal completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Every access is a full 32-bit word read.
    localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/wb_stream_reader_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : Synchronous first-word-fall-through FIFO. dout always shows
//               the oldest entry while empty is low.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               flush      - discard all contents (dominates push/pop)
//               push, din  - write din when not full (or when popping)
//               pop        - drop the head entry when not empty
//               dout       - head entry
//               empty/full - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2 + 1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2 + 1)'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/wb_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : wb_stream_reader
// Description : Wishbone classic-cycle master that reads a block of 32-bit
//               words and delivers them on a valid/ready stream through an
//               internal FWFT FIFO.
// Ports       : clk, reset                  - clock, sync active-high reset
//               start, base_adr, length     - transfer request (when idle)
//               abort                       - cancel and flush
//               busy, done, error           - transfer status
//               wb_*                        - Wishbone master interface
//               out_data/out_valid/out_ready- output stream
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stream_reader
    import wb_stream_reader_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          base_adr,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          wb_adr_o,
    input  logic [31:0]          wb_dat_i,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic                 wb_rty_i,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t               r_state;
    state_t               w_state_next;
    logic [31:0]          r_adr;
    logic [31:0]          w_adr_next;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic [LEN_WIDTH-1:0] w_remaining_next;
    logic                 r_cyc;
    logic                 w_cyc_next;
    logic                 r_error;
    logic                 w_error_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_empty;
    logic                 w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_adr       <= '0;
            r_remaining <= '0;
            r_cyc       <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_adr       <= w_adr_next;
            r_remaining <= w_remaining_next;
            r_cyc       <= w_cyc_next;
            r_error     <= w_error_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_adr_next       = r_adr;
        w_remaining_next = r_remaining;
        w_cyc_next       = r_cyc;
        w_error_next     = r_error;
        w_push           = 1'b0;
        w_flush          = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_adr_next       = base_adr & ~32'h3;
                    w_remaining_next = length;
                    w_error_next     = 1'b0;
                    w_state_next     = (length == '0) ? DONE : REQ;
                end
            end

            REQ: begin
                if (abort) begin
                    // Any termination arriving with the abort is dropped.
                    w_cyc_next   = 1'b0;
                    w_flush      = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cyc) begin
                    if (wb_err_i) begin
                        // Error takes priority over a simultaneous ack.
                        w_cyc_next   = 1'b0;
                        w_error_next = 1'b1;
                        w_state_next = DONE;
                    end else if (wb_ack_i) begin
                        w_push           = 1'b1;
                        w_adr_next       = r_adr + 32'd4;
                        w_remaining_next = r_remaining - LEN_WIDTH'(1);
                        w_cyc_next       = 1'b0;
                        if (r_remaining == LEN_WIDTH'(1)) w_state_next = DONE;
                    end else if (wb_rty_i) begin
                        // Same address is reissued after the idle cycle.
                        w_cyc_next = 1'b0;
                    end
                end else if (!w_full) begin
                    // Only start an access when its data is sure to fit; the
                    // idle cycle after each termination falls out of this.
                    w_cyc_next = 1'b1;
                end
            end

            DONE: begin
                w_state_next = IDLE;
                if (abort) w_flush = 1'b1;
            end

            default: w_state_next = IDLE;
        endcase
    end

    assign w_pop = !w_empty && out_ready;

    stream_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .flush (w_flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wb_dat_i),
        .dout  (out_data),
        .empty (w_empty),
        .full  (w_full)
    );

    assign busy      = (r_state == REQ);
    assign done      = (r_state == DONE);
    assign error     = r_error;
    assign wb_adr_o  = r_adr;
    assign wb_sel_o  = WB_SEL_ALL;
    assign wb_we_o   = 1'b0;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign out_valid = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_wb_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stream_reader
// Description : Directed self-checking bench for wb_stream_reader with a
//               behavioural Wishbone slave and a stream consumer monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_adr;
    logic [15:0] length;
    logic        abort;
    logic        busy, done, error;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Slave configuration (written by the stimulus only)
    int wait_even = 0;
    int wait_odd  = 0;
    int err_at    = -1;
    int rty_at    = -1;

    // Slave / monitor state (written by the model processes only)
    int          s_wait = 0;
    int          s_acc = 0;
    bit          s_resp = 1'b0;
    bit          cyc_prev = 1'b0;
    int          low_run = 1000;
    int          rise_cnt = 0;
    int          err_cnt = 0;
    int          rty_cnt = 0;
    int          rty_rise = 0;
    int          done_cnt = 0;
    int          done_busy = 0;
    logic [31:0] adr_log[$];
    logic [31:0] rx[$];
    int          gaps[$];

    always #5 clk = ~clk;

    wb_stream_reader #(
        .FIFO_DEPTH_LOG2 (2),
        .LEN_WIDTH       (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_adr  (base_adr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_rty_i  (wb_rty_i),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Slave: responds on the falling edge so the DUT sees a stable
    // termination at the next rising edge. Read data is ~address.
    always @(negedge clk) begin
        int cur_wait;
        if (wb_cyc_o && !cyc_prev) begin
            gaps.push_back(low_run);
            rise_cnt++;
        end
        low_run  = wb_cyc_o ? 0 : low_run + 1;
        cyc_prev = wb_cyc_o;

        if (reset) begin
            s_resp = 1'b0; s_wait = 0;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        end else if (s_resp) begin
            s_resp = 1'b0;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            cur_wait = (s_acc % 2 == 1) ? wait_odd : wait_even;
            if (s_wait >= cur_wait) begin
                if (s_acc == err_at) begin
                    wb_err_i = 1'b1; err_cnt++;
                end else if (s_acc == rty_at) begin
                    wb_rty_i = 1'b1; rty_cnt++; rty_rise = rise_cnt;
                end else begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = ~wb_adr_o;
                    adr_log.push_back(wb_adr_o);
                end
                s_acc++;
                s_resp = 1'b1;
                s_wait = 0;
            end else begin
                s_wait++;
            end
        end else begin
            s_wait = 0;
        end
    end

    // Consumer monitor: a word is accepted at the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) rx.push_back(out_data);
        if (!reset && done) begin
            done_cnt++;
            if (busy) done_busy++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [31:0] adr, input int len);
        base_adr = adr;
        length   = 16'(len);
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && done_cnt < target; i++) tick(1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && out_valid; i++) tick(1);
    endtask

    task automatic wait_acks_cyc(input int target);
        for (int i = 0; i < 400 && !(adr_log.size() >= target && wb_cyc_o); i++) tick(1);
    endtask

    task automatic verify_stream(input string tag, input logic [31:0] base,
                                 input int n, input int a0, input int r0);
        chk($sformatf("%s_acks", tag), 32'(adr_log.size() - a0), 32'(n));
        chk($sformatf("%s_words", tag), 32'(rx.size() - r0), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [31:0] ea, ga, gd;
            ea = base + 32'(4 * i);
            ga = (a0 + i < adr_log.size()) ? adr_log[a0 + i] : 32'hxxxx_xxxx;
            gd = (r0 + i < rx.size()) ? rx[r0 + i] : 32'hxxxx_xxxx;
            chk($sformatf("%s_adr%0d", tag, i), ga, ea);
            chk($sformatf("%s_dat%0d", tag, i), gd, ~ea);
        end
    endtask

    initial begin
        int a0, r0, d0, c0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_adr = '0; length = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        tick(3);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_sel", wb_sel_o, 4'hF);
        reset = 1'b0;
        tick(2);

        // 1: four words, alternating 0 and 3 wait states, consumer ready
        wait_even = 0; wait_odd = 3; out_ready = 1'b1;
        a0 = adr_log.size(); r0 = rx.size(); d0 = done_cnt;
        start_xfer(32'h4000_0000, 4);
        chk("t1_busy", busy, 1);
        wait_done(d0 + 1);
        wait_drain();
        tick(3);
        chk("t1_done_cnt", 32'(done_cnt - d0), 1);
        chk("t1_busy_at_done", 32'(done_busy), 0);
        chk("t1_busy_after", busy, 0);
        verify_stream("t1", 32'h4000_0000, 4, a0, r0);

        // 2: backpressure with a 4-entry FIFO
        wait_even = 0; wait_odd = 0; out_ready = 1'b0;
        a0 = adr_log.size(); r0 = rx.size(); d0 = done_cnt; c0 = rise_cnt;
        start_xfer(32'h0000_1000, 10);
        tick(40);
        chk("t2_acks_full", 32'(adr_log.size() - a0), 4);
        chk("t2_rises_full", 32'(rise_cnt - c0), 4);
        chk("t2_cyc_held", wb_cyc_o, 0);
        chk("t2_busy_full", busy, 1);
        chk("t2_valid_full", out_valid, 1);
        out_ready = 1'b1;
        wait_done(d0 + 1);
        wait_drain();
        tick(2);
        chk("t2_done_cnt", 32'(done_cnt - d0), 1);
        verify_stream("t2", 32'h0000_1000, 10, a0, r0);

        // 3: zero length
        d0 = done_cnt; c0 = rise_cnt;
        start_xfer(32'h0000_2000, 0);
        chk("t3_done_next", done, 1);
        chk("t3_busy", busy, 0);
        tick(1);
        chk("t3_done_once", done, 0);
        tick(3);
        chk("t3_done_cnt", 32'(done_cnt - d0), 1);
        chk("t3_no_cyc", 32'(rise_cnt - c0), 0);
        chk("t3_error", error, 0);

        // 4: error on the third access
        a0 = adr_log.size(); r0 = rx.size(); d0 = done_cnt; c0 = rise_cnt;
        err_at = s_acc + 2;
        start_xfer(32'h0000_3000, 5);
        wait_done(d0 + 1);
        wait_drain();
        tick(10);
        err_at = -1;
        chk("t4_error", error, 1);
        chk("t4_done_cnt", 32'(done_cnt - d0), 1);
        chk("t4_rises", 32'(rise_cnt - c0), 3);
        verify_stream("t4", 32'h0000_3000, 2, a0, r0);

        // 5: retry on the first access
        a0 = adr_log.size(); r0 = rx.size(); d0 = done_cnt;
        rty_at = s_acc;
        start_xfer(32'h0000_5000, 2);
        chk("t5_error_cleared", error, 0);
        wait_done(d0 + 1);
        wait_drain();
        tick(2);
        rty_at = -1;
        chk("t5_rty_cnt", 32'(rty_cnt), 1);
        chk("t5_rty_gap", (rty_rise < gaps.size()) ? 32'(gaps[rty_rise]) : 32'hxxxx_xxxx, 1);
        verify_stream("t5", 32'h0000_5000, 2, a0, r0);

        // 6: address wrap, low bits of base ignored
        a0 = adr_log.size(); r0 = rx.size(); d0 = done_cnt;
        start_xfer(32'hFFFF_FFFF, 2);
        wait_done(d0 + 1);
        wait_drain();
        tick(2);
        verify_stream("t6", 32'hFFFF_FFFC, 2, a0, r0);

        // 7: abort with an access in flight after two words
        wait_even = 3; wait_odd = 3; out_ready = 1'b0;
        a0 = adr_log.size(); d0 = done_cnt; c0 = rise_cnt;
        start_xfer(32'h0000_6000, 8);
        wait_acks_cyc(a0 + 2);
        chk("t7_acks_before", 32'(adr_log.size() - a0), 2);
        chk("t7_cyc_before", wb_cyc_o, 1);
        chk("t7_valid_before", out_valid, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t7_cyc", wb_cyc_o, 0);
        chk("t7_stb", wb_stb_o, 0);
        chk("t7_valid", out_valid, 0);
        chk("t7_busy", busy, 0);
        tick(10);
        chk("t7_no_done", 32'(done_cnt - d0), 0);
        chk("t7_no_reissue", 32'(rise_cnt - c0), 3);
        chk("t7_acks_after", 32'(adr_log.size() - a0), 2);

        // 8: reset with an access in flight after two words
        a0 = adr_log.size();
        start_xfer(32'h0000_7000, 8);
        wait_acks_cyc(a0 + 2);
        chk("t8_cyc_before", wb_cyc_o, 1);
        reset = 1'b1;
        tick(1);
        chk("t8_cyc", wb_cyc_o, 0);
        chk("t8_stb", wb_stb_o, 0);
        chk("t8_adr", wb_adr_o, 0);
        chk("t8_busy", busy, 0);
        chk("t8_done", done, 0);
        chk("t8_error", error, 0);
        chk("t8_valid", out_valid, 0);
        reset = 1'b0;
        tick(5);
        chk("t8_idle_cyc", wb_cyc_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
